mem_responder: RTL and testbench

- Memory-side responder for the core's strobe/ready memory interface. This is the target that the data cache's miss/write-back path and uncached path drive.
- Accepts one word-addressed read or byte-enabled write per transaction and inserts a programmable number of wait states.
- Returns data and a one-cycle ready pulse, backed by an internal word-wide RAM.
- Used as the behavioural/FPGA-BRAM memory model behind the cache in simulation and small builds.

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the strobe/ready memory interface driven by the
// data cache (miss/write-back path and uncached path). Each transaction is a
// single word-addressed read or byte-enabled write. The responder waits a
// programmable number of cycles, touches its internal RAM, and then pulses
// m_ready for one cycle.
//
// Optional feature macro: MEM_RESP_RAND_WAIT_EN
//   Defined   : an 8-bit LFSR adds 0..3 extra wait states per request so the
//               initiator's ready handling gets stressed.
//   Undefined : every request waits exactly WAIT_CYCLES.
//
// Parameters:
//   A_WIDTH     - width of the byte address m_a
//   DEPTH_LOG2  - log2 of the RAM depth in 32-bit words
//   WAIT_CYCLES - wait states between request accept and ready (0 allowed)
//
// Ports:
//   clk       in   clock, everything on posedge
//   rst       in   synchronous active-high reset
//   m_a       in   byte address; word index is m_a[DEPTH_LOG2+1:2]
//   m_din     in   write data
//   m_dout    out  registered read data, held until the next read completes
//   m_strobe  in   request valid, held by the initiator until ready
//   m_wen     in   byte enables, bit3 -> [31:24] ... bit0 -> [7:0]
//   m_size    in   access size, captured for information only
//   m_rw      in   1 = write, 0 = read
//   m_ready   out  one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int A_WIDTH     = 32,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    output logic [31:0]        m_dout,
    input  logic               m_strobe,
    input  logic [3:0]         m_wen,
    input  logic [1:0]         m_size,
    input  logic               m_rw,
    output logic               m_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Wide enough for WAIT_CYCLES plus the largest random extension.
    localparam int CNT_W = $clog2(WAIT_CYCLES + 4) + 1;
    localparam logic [CNT_W-1:0] WAIT_BASE = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        wait_cnt;
    logic [CNT_W-1:0]        eff_wait;

    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             din_q;
    logic [3:0]              wen_q;
    logic                    rw_q;
    logic [1:0]              size_q;

    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [31:0]             req_din;
    logic [3:0]              req_wen;
    logic                    req_rw;
    logic                    commit;

    logic [31:0]             mem [DEPTH];

    // Address bits outside the word index and the captured size have no
    // effect on behaviour; folding them here keeps them visibly intentional.
    logic                    unused_bits;
    assign unused_bits = ^{m_a[A_WIDTH-1:DEPTH_LOG2+2], m_a[1:0], size_q};

`ifdef MEM_RESP_RAND_WAIT_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Fibonacci LFSR, taps 8,6,5,4. The low two bits are sampled for the
    // request being accepted, then the register advances on that same edge.
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign eff_wait = WAIT_BASE + CNT_W'(lfsr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (state == S_IDLE && m_strobe) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    assign eff_wait = WAIT_BASE;
`endif

    // With zero wait states the RAM is touched on the accept edge itself,
    // before the latch registers hold the request, so in IDLE the live
    // inputs stand in for the latched copy.
    always_comb begin
        req_idx = idx_q;
        req_din = din_q;
        req_wen = wen_q;
        req_rw  = rw_q;
        commit  = 1'b0;
        if (state == S_IDLE) begin
            req_idx = m_a[DEPTH_LOG2+1:2];
            req_din = m_din;
            req_wen = m_wen;
            req_rw  = m_rw;
        end
        if (!rst) begin
            commit = (state == S_IDLE && m_strobe && eff_wait == '0) ||
                     (state == S_WAIT && wait_cnt == '0);
        end
    end

    // Transaction sequencer. m_ready is raised on the edge that enters RESP
    // so it is high for exactly the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            m_ready  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    m_ready <= 1'b0;
                    if (m_strobe) begin
                        idx_q  <= m_a[DEPTH_LOG2+1:2];
                        din_q  <= m_din;
                        wen_q  <= m_wen;
                        rw_q   <= m_rw;
                        size_q <= m_size;
                        if (eff_wait == '0) begin
                            state   <= S_RESP;
                            m_ready <= 1'b1;
                        end else begin
                            wait_cnt <= eff_wait - CNT_W'(1);
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state   <= S_RESP;
                        m_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    m_ready <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    m_ready <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // RAM write port. No reset on the array; a write aborted by reset never
    // reaches here because commit is gated by rst.
    always_ff @(posedge clk) begin
        if (commit && req_rw) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wen[b]) begin
                    mem[req_idx][8*b +: 8] <= req_din[8*b +: 8];
                end
            end
        end
    end

    // Registered read data; only a completing read changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_dout <= 32'h0;
        end else if (commit && !req_rw) begin
            m_dout <= mem[req_idx];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A transaction-level model predicts
// m_ready and m_dout for every cycle from accept times and a word array; a
// compare process checks the main DUT (WAIT_CYCLES=2) against it on every
// falling edge. Directed transactions pin the model with literal values, a
// randomized phase follows, and a second instance with WAIT_CYCLES=0 checks
// back-to-back ready spacing.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int W = 2;
    localparam logic [31:0] B2B_BASE = 32'h0A0B0C0D;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_a, m_din, m_dout;
    logic        m_strobe, m_rw, m_ready;
    logic [3:0]  m_wen;
    logic [1:0]  m_size;

    logic [31:0] b_a, b_din, b_dout;
    logic        b_strobe, b_rw, b_ready;
    logic [3:0]  b_wen;
    logic [1:0]  b_size;

    int vectors = 0;
    int miscompares = 0;
    bit held = 0;

    always #5 clk = ~clk;

    mem_responder #(.A_WIDTH(32), .DEPTH_LOG2(12), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
        .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
        .m_ready(m_ready)
    );

    mem_responder #(.A_WIDTH(32), .DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut_b2b (
        .clk(clk), .rst(rst), .m_a(b_a), .m_din(b_din), .m_dout(b_dout),
        .m_strobe(b_strobe), .m_wen(b_wen), .m_size(b_size), .m_rw(b_rw),
        .m_ready(b_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Transaction-level model: a request is taken on any edge at or after
    // next_accept while strobe is high, completes W edges later, and the
    // responder is free again two edges after completion.
    logic [31:0] model_mem [int];
    bit          model_valid = 0;
    bit          pend = 0;
    bit          exp_ready = 0;
    bit          dout_known = 0;
    logic [31:0] exp_dout = '0;
    int          edge_n = 0;
    int          next_accept = 0;
    int          due = 0;
    int          p_idx;
    logic [31:0] p_din;
    logic [3:0]  p_wen;
    logic        p_rw;

    always @(posedge clk) begin
        logic [31:0] w;
        edge_n++;
        if (rst) begin
            model_valid = 1;
            pend        = 0;
            exp_ready   = 0;
            exp_dout    = '0;
            dout_known  = 1;
            next_accept = edge_n + 1;
        end else if (model_valid) begin
            exp_ready = 0;
            if (!pend && edge_n >= next_accept && m_strobe === 1'b1) begin
                pend  = 1;
                due   = edge_n + W;
                p_idx = int'((m_a >> 2) & 32'hFFF);
                p_din = m_din;
                p_wen = m_wen;
                p_rw  = m_rw;
            end
            if (pend && edge_n == due) begin
                if (p_rw) begin
                    if (model_mem.exists(p_idx)) begin
                        w = model_mem[p_idx];
                        for (int b = 0; b < 4; b++)
                            if (p_wen[b]) w[8*b +: 8] = p_din[8*b +: 8];
                        model_mem[p_idx] = w;
                    end else if (p_wen == 4'hF) begin
                        model_mem[p_idx] = p_din;
                    end
                end else begin
                    dout_known = model_mem.exists(p_idx);
                    if (dout_known) exp_dout = model_mem[p_idx];
                end
                exp_ready   = 1;
                pend        = 0;
                next_accept = edge_n + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_ready", 32'(m_ready), 32'(exp_ready));
            if (dout_known) checkOutput("model_dout", m_dout, exp_dout);
        end
    end

    // Drives one transaction starting at a falling edge and waits (bounded)
    // for ready. mode 1 scrambles inputs after accept, mode 2 drops strobe.
    task automatic applyStimulus(input logic rw, input logic [31:0] a,
                                 input logic [31:0] din, input logic [3:0] wen,
                                 input bit hold_next, input int mode,
                                 output logic [31:0] rd);
        int cycles;
        bit got;
        int exp_lat;
        exp_lat  = held ? W + 2 : W + 1;
        m_a      = a;
        m_din    = din;
        m_wen    = wen;
        m_rw     = rw;
        m_size   = 2'($urandom_range(0, 2));
        m_strobe = 1'b1;
        cycles   = 0;
        got      = 0;
        rd       = 'x;
        while (!got && cycles < 40) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (m_ready === 1'b1) begin
                got = 1;
                rd  = m_dout;
            end else if (cycles >= (held ? 2 : 1)) begin
                if (mode == 1) begin
                    m_a   = $urandom;
                    m_din = $urandom;
                    m_wen = 4'($urandom);
                end
                if (mode == 2) m_strobe = 1'b0;
            end
        end
        checkOutput("latency", 32'(cycles), 32'(exp_lat));
        held = hold_next;
        if (!hold_next) begin
            m_strobe = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic setB(input int t);
        b_strobe = 1'b1;
        b_size   = 2'd2;
        b_wen    = 4'hF;
        if (t < 3) begin
            b_rw  = 1'b1;
            b_a   = 32'(4 * t);
            b_din = B2B_BASE + 32'(t);
        end else begin
            b_rw  = 1'b0;
            b_a   = 32'(4 * (t - 3));
            b_din = $urandom;
        end
    endtask

    function automatic logic [31:0] pool_addr();
        return ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_b;
        bit          hold;
        rst = 1'b1;
        m_a = '0; m_din = '0; m_wen = '0; m_rw = 1'b0; m_size = '0; m_strobe = 1'b0;
        b_a = '0; b_din = '0; b_wen = '0; b_rw = 1'b0; b_size = '0; b_strobe = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("idle_ready", 32'(m_ready), 32'h0);
            checkOutput("idle_dout", m_dout, 32'h0);
        end

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 32'h80, 32'h0, 4'hF, 0, 0, rd);
        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, rd);
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 0, 0, rd);
        checkOutput("read_100", rd, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h40, 32'h11223344, 4'hF, 0, 0, rd);
        applyStimulus(1'b1, 32'h40, 32'hAA000000 | 32'h00BB0000, 4'b0100, 0, 0, rd);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 0, 0, rd);
        checkOutput("byte_merge", rd, 32'h11BB3344);
        applyStimulus(1'b1, 32'h4004, 32'h5A5A5A5A, 4'hF, 0, 0, rd);
        applyStimulus(1'b0, 32'h0004, 32'h0, 4'h0, 0, 0, rd);
        checkOutput("alias", rd, 32'h5A5A5A5A);
        applyStimulus(1'b1, 32'h40, 32'h0, 4'h0, 0, 0, rd);
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 0, 1, rd);
        checkOutput("scramble_read", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 0, 2, rd);
        checkOutput("drop_strobe_read", rd, 32'h11BB3344);
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 1, 0, rd);
        checkOutput("held_read0", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 1, 0, rd);
        checkOutput("held_read1", rd, 32'h11BB3344);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 0, 0, rd);
        checkOutput("held_read2", rd, 32'h5A5A5A5A);

        $display("[TB] reset during wait");
        m_a = 32'h80; m_din = 32'hFFFFFFFF; m_wen = 4'hF; m_rw = 1'b1; m_strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_wait_ready", 32'(m_ready), 32'h0);
        rst = 1'b1;
        m_strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_ready", 32'(m_ready), 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        held = 0;
        applyStimulus(1'b0, 32'h80, 32'h0, 4'h0, 0, 0, rd);
        checkOutput("abort_read", rd, 32'h0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, ($urandom & 32'hFFFF_C000) | 32'(i << 2), $urandom,
                          4'hF, 0, 0, rd);
        for (int i = 0; i < 250; i++) begin
            hold = (i < 249) ? 1'($urandom) : 1'b0;
            applyStimulus(1'($urandom), pool_addr(), $urandom, 4'($urandom), hold,
                          $urandom_range(0, 2), rd);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] back-to-back with zero wait states");
        setB(0);
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_b = (n / 2 >= 3) ? B2B_BASE + 32'(n / 2 - 3) : 32'h0;
            checkOutput("b2b_ready", 32'(b_ready), 32'((n % 2) == 0));
            checkOutput("b2b_dout", b_dout, exp_b);
            if (n % 2 == 0) begin
                if (n / 2 < 5) setB(n / 2 + 1);
                else b_strobe = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
